// File: rtl/inst_fetch_if.sv
// Instruction memory read bus between the fetch stage (master) and instruction memory (slave).
interface inst_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  modport master (output mem_req, mem_addr, input mem_ack, mem_data);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding memory reads, prefetch FIFO and branch redirect.
// Optional HALT-opcode stop is enabled with `define INST_FETCH_HALT_EN.
module inst_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OP  = 5'b11111
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_en,
  input  logic             I_branch_en,
  input  logic [15:0]      I_branch_addr,
  inst_fetch_if.master     mem,
  output logic [15:0]      O_inst,
  output logic [15:0]      O_pc,
  output logic             O_valid,
  output logic             O_halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DRAIN
`ifdef INST_FETCH_HALT_EN
    , S_HALT
`endif
  } state_e;

  state_e                   state_q, state_d;
  logic [15:0]              fetch_pc_q, fetch_pc_d;
  logic                     req_q, req_d;
  logic [15:0]              addr_q, addr_d;
  logic [AW-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DEPTH-1:0][15:0]   inst_q, inst_d;
  logic [DEPTH-1:0][15:0]   pcs_q, pcs_d;
  logic                     ack, push, pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    pcs_d      = pcs_q;
    ack        = req_q && mem.mem_ack;
    push       = 1'b0;
    pop        = 1'b0;
    if (I_branch_en) begin
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      fetch_pc_d = I_branch_addr;
      // An unanswered read must still complete; its data is dropped in DRAIN.
      if (req_q && !ack) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        addr_d  = I_branch_addr;
      end
    end else if (state_q == S_DRAIN) begin
      if (ack) begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        addr_d  = fetch_pc_q;
      end
    end else begin
      push = ack;
      pop  = I_en && (cnt_q != '0);
      if (push) begin
        inst_d[wr_q] = mem.mem_data;
        pcs_d[wr_q]  = fetch_pc_q;
        wr_d         = wr_q + AW'(1);
        fetch_pc_d   = fetch_pc_q + 16'd1;
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      // Outstanding read keeps req/addr frozen; otherwise request if a slot is free.
      if (!(req_q && !ack)) begin
        req_d  = (cnt_d < DEPTH_C);
        addr_d = fetch_pc_d;
`ifdef INST_FETCH_HALT_EN
        if (state_q == S_HALT || (push && mem.mem_data[15:11] == HALT_OP)) begin
          state_d = S_HALT;
          req_d   = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      inst_q     <= '0;
      pcs_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      pcs_q      <= pcs_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign O_valid      = (cnt_q != '0);
  assign O_inst       = inst_q[rd_q];
  assign O_pc         = pcs_q[rd_q];
`ifdef INST_FETCH_HALT_EN
  assign O_halted     = (state_q == S_HALT);
`else
  assign O_halted     = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Directed scenarios plus randomized latency/consumer/branch traffic against an address-stream model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst, en, br_en;
  logic [15:0] br_addr;
  logic [15:0] inst, pc;
  logic        valid, halted;

  inst_fetch_if bus();

  inst_fetch #(.DEPTH(2)) dut (
    .I_clk(clk), .I_rst(rst), .I_en(en), .I_branch_en(br_en), .I_branch_addr(br_addr),
    .mem(bus.master), .O_inst(inst), .O_pc(pc), .O_valid(valid), .O_halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int lat_mode, wait_cnt, ack_cnt;
  bit halt_inj;
  bit pend;
  logic [15:0] pend_addr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: a scrambled function of the address that never hits the HALT opcode.
  function automatic logic [15:0] memf(logic [15:0] a);
    if (halt_inj && a == 16'h0005) return 16'hF800;
    return (a * 16'h9E37 + 16'h1234) & 16'h7FFF;
  endfunction

  function int lat_fn();
    return (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
  endfunction

  // Memory responder: each request waits lat cycles, then acks with memf(addr).
  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (rst) begin
      wait_cnt = lat_fn();
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("req_hold", 32'(bus.mem_req), 32'd1);
        chk("addr_hold", 32'(bus.mem_addr), 32'(pend_addr));
      end
      pend = 1'b0;
      if (bus.mem_req) begin
        if (wait_cnt == 0) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = memf(bus.mem_addr);
          ack_cnt++;
          wait_cnt = lat_fn();
        end else begin
          wait_cnt--;
          pend = 1'b1;
          pend_addr = bus.mem_addr;
        end
      end
    end
  end

  task automatic do_reset(int lat);
    rst = 1'b1; en = 1'b0; br_en = 1'b0; lat_mode = lat;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(string tag, int limit);
    int n = 0;
    while (!valid && n < limit) begin @(negedge clk); n++; end
    chk(tag, 32'(n < limit), 32'd1);
  endtask

  initial begin
    logic [15:0] exp_pc;
    int pops, n;
    bit seen;
    rst = 1'b1; en = 1'b0; br_en = 1'b0; br_addr = '0; lat_mode = 0; halt_inj = 1'b0;
    ack_cnt = 0; pend = 1'b0; pend_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_data = '0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_inst", 32'(inst), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);

    // 1: ack every cycle, consumer always ready
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("t1_valid_early", 32'(valid), 0);
    chk("t1_req", 32'(bus.mem_req), 1);
    chk("t1_addr", 32'(bus.mem_addr), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(valid), 1);
      chk("t1_pc", 32'(pc), 32'(i));
      chk("t1_inst", 32'(inst), 32'(memf(16'(i))));
    end

    // 2: consumer stalled fills the FIFO, one pop resumes fetch
    do_reset(0);
    ack_cnt = 0;
    repeat (6) @(negedge clk);
    chk("t2_acks", 32'(ack_cnt), 2);
    chk("t2_req_full", 32'(bus.mem_req), 0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("t2_req_resume", 32'(bus.mem_req), 1);
    chk("t2_addr_resume", 32'(bus.mem_addr), 2);

    // 3: branch while a slow read is outstanding
    do_reset(3);
    en = 1'b1;
    @(negedge clk);
    chk("t3_req", 32'(bus.mem_req), 1);
    br_en = 1'b1; br_addr = 16'h0040;
    @(negedge clk);
    br_en = 1'b0;
    chk("t3_valid_off", 32'(valid), 0);
    chk("t3_addr_held", 32'(bus.mem_addr), 0);
    n = 0; seen = 1'b0;
    while (!valid && n < 30) begin
      if (bus.mem_req && bus.mem_addr != 16'h0000 && !seen) begin
        chk("t3_next_addr", 32'(bus.mem_addr), 32'h0040);
        seen = 1'b1;
      end
      @(negedge clk); n++;
    end
    chk("t3_timeout", 32'(n < 30), 1);
    chk("t3_pc", 32'(pc), 32'h0040);
    chk("t3_inst", 32'(inst), 32'(memf(16'h0040)));

    // 4: branch coincides with ack
    do_reset(0);
    @(negedge clk);
    chk("t4_req", 32'(bus.mem_req), 1);
    br_en = 1'b1; br_addr = 16'h0100;
    @(negedge clk);
    br_en = 1'b0;
    chk("t4_valid_off", 32'(valid), 0);
    chk("t4_addr", 32'(bus.mem_addr), 32'h0100);
    @(negedge clk);
    chk("t4_valid", 32'(valid), 1);
    chk("t4_pc", 32'(pc), 32'h0100);

    // 5: PC wraps
    do_reset(0);
    en = 1'b1;
    @(negedge clk);
    br_en = 1'b1; br_addr = 16'hFFFF;
    @(negedge clk);
    br_en = 1'b0;
    wait_valid("t5_timeout", 10);
    chk("t5_pc0", 32'(pc), 32'hFFFF);
    @(negedge clk);
    chk("t5_valid1", 32'(valid), 1);
    chk("t5_pc1", 32'(pc), 32'h0000);

    // 6: HALT opcode at address 5
    do_reset(0);
    halt_inj = 1'b1; en = 1'b1;
    n = 0;
    while (!(valid && pc == 16'h0005) && n < 40) begin @(negedge clk); n++; end
    chk("t6_timeout", 32'(n < 40), 1);
    chk("t6_inst", 32'(inst), 32'hF800);
`ifdef INST_FETCH_HALT_EN
    chk("t6_halted", 32'(halted), 1);
    chk("t6_req_off", 32'(bus.mem_req), 0);
    repeat (3) @(negedge clk);
    chk("t6_req_still_off", 32'(bus.mem_req), 0);
    br_en = 1'b1; br_addr = 16'h0000;
    @(negedge clk);
    br_en = 1'b0;
    chk("t6_unhalted", 32'(halted), 0);
    chk("t6_req_on", 32'(bus.mem_req), 1);
    chk("t6_req_addr", 32'(bus.mem_addr), 0);
`else
    chk("t6_halted", 32'(halted), 0);
    @(negedge clk);
    chk("t6_valid_next", 32'(valid), 1);
    chk("t6_pc_next", 32'(pc), 6);
`endif
    halt_inj = 1'b0;

    // random: delivered words must match memory and follow the expected PC stream
    do_reset(-1);
    exp_pc = 16'h0000; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      if (valid) chk("rnd_inst", 32'(inst), 32'(memf(pc)));
      br_en   = ($urandom_range(15, 0) == 0);
      br_addr = $urandom_range(1, 0) ? 16'($urandom) : 16'hFFFE;
      en      = ($urandom_range(3, 0) != 0);
      if (!br_en && en && valid) begin
        chk("rnd_pc", 32'(pc), 32'(exp_pc));
        exp_pc = exp_pc + 16'd1;
        pops++;
      end
      if (br_en) exp_pc = br_addr;
      @(negedge clk);
    end
    br_en = 1'b0; en = 1'b0;
    chk("rnd_progress", 32'(pops > 200), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
